// File: rtl/spike_rate_if.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rate_if
//  Brief    : Spike input, rate word handshake and ISI result bundle.
//  Revision : 1.0
// ============================================================================
interface spike_rate_if #(
    parameter int COUNT_W = 8,
    parameter int ISI_W   = 8
);
    logic               enable;
    logic               spike_in;
    logic [COUNT_W-1:0] rate_out;
    logic               rate_valid;
    logic               rate_ready;
    logic               overrun;
    logic [ISI_W-1:0]   isi_out;
    logic               isi_valid;

    modport master (
        input  enable,
        input  spike_in,
        input  rate_ready,
        output rate_out,
        output rate_valid,
        output overrun,
        output isi_out,
        output isi_valid
    );

    modport slave (
        output enable,
        output spike_in,
        output rate_ready,
        input  rate_out,
        input  rate_valid,
        input  overrun,
        input  isi_out,
        input  isi_valid
    );
endinterface
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rate_decoder
//  Brief    : Counts spike edges per fixed window into a rate word and
//             measures inter-spike interval in clock cycles.
//  Revision : 1.0
// ============================================================================
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int COUNT_W     = 8,
    parameter int ISI_W       = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    spike_rate_if.master    bus
);
    localparam logic [WINDOW_LOG2-1:0] c_WIN_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] c_WIN_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]     c_CNT_MAX  = '1;
    localparam logic [ISI_W-1:0]       c_ISI_MAX  = '1;
    localparam logic [ISI_W-1:0]       c_ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_spike_q;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [COUNT_W-1:0]     r_spk_cnt;
    logic [ISI_W-1:0]       r_isi_tmr;
    logic                   r_have_prev;
    logic [COUNT_W-1:0]     r_rate_out;
    logic                   r_rate_valid;
    logic                   r_overrun;
    logic [ISI_W-1:0]       r_isi_out;
    logic                   r_isi_valid;

    logic                   w_edge;
    logic                   w_accept;
    logic [COUNT_W-1:0]     w_spk_sat;
    logic [ISI_W-1:0]       w_isi_inc;

    assign w_edge    = bus.spike_in & ~r_spike_q;
    assign w_accept  = r_rate_valid & bus.rate_ready;
    // Count including this cycle's edge, pinned at full scale.
    assign w_spk_sat = (r_spk_cnt == c_CNT_MAX) ? c_CNT_MAX
                     : r_spk_cnt + {{(COUNT_W-1){1'b0}}, w_edge};
    assign w_isi_inc = (r_isi_tmr == c_ISI_MAX) ? c_ISI_MAX : r_isi_tmr + c_ISI_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_spike_q    <= 1'b0;
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_isi_tmr    <= '0;
            r_have_prev  <= 1'b0;
            r_rate_out   <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_isi_out    <= '0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_spike_q   <= bus.spike_in;
            r_isi_valid <= 1'b0;
            if (w_accept) begin
                r_rate_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_win_cnt   <= '0;
                    r_spk_cnt   <= '0;
                    r_isi_tmr   <= '0;
                    r_have_prev <= 1'b0;
                    if (bus.enable) begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!bus.enable) begin
                        r_state     <= S_IDLE;
                        r_win_cnt   <= '0;
                        r_spk_cnt   <= '0;
                        r_isi_tmr   <= '0;
                        r_have_prev <= 1'b0;
                    end else begin
                        r_win_cnt <= r_win_cnt + c_WIN_ONE;
                        // Window close publishes and restarts with no dead cycle;
                        // this load takes priority over the accept clear above.
                        if (r_win_cnt == c_WIN_LAST) begin
                            r_rate_out   <= w_spk_sat;
                            r_rate_valid <= 1'b1;
                            r_spk_cnt    <= '0;
                            if (r_rate_valid && !bus.rate_ready) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_spk_cnt <= w_spk_sat;
                        end
                        if (w_edge) begin
                            r_isi_tmr   <= c_ISI_ONE;
                            r_have_prev <= 1'b1;
                            if (r_have_prev) begin
                                r_isi_out   <= r_isi_tmr;
                                r_isi_valid <= 1'b1;
                            end
                        end else begin
                            r_isi_tmr <= w_isi_inc;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rate_out   = r_rate_out;
    assign bus.rate_valid = r_rate_valid;
    assign bus.overrun    = r_overrun;
    assign bus.isi_out    = r_isi_out;
    assign bus.isi_valid  = r_isi_valid;
endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_rate_decoder
//  Brief    : Directed stimulus against a timestamp-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_spike_rate_decoder;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spike_rate_if #(.COUNT_W(8), .ISI_W(8)) bus ();

    spike_rate_decoder #(
        .WINDOW_LOG2(8),
        .COUNT_W    (8),
        .ISI_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference: windows located by absolute cycle number, ISI by edge timestamps.
    int m_cyc       = 0;
    bit m_counting  = 1'b0;
    int m_win_start = 0;
    int m_spikes    = 0;
    bit m_prev      = 1'b0;
    int m_last      = -1;
    int e_rate      = 0;
    bit e_rv        = 1'b0;
    bit e_ovr       = 1'b0;
    int e_isi       = 0;
    bit e_iv        = 1'b0;

    always @(posedge clk) begin : model
        bit edge_s;
        bit rv_before;
        if (reset) begin
            m_counting = 1'b0;
            m_spikes   = 0;
            m_last     = -1;
            e_rate     = 0;
            e_rv       = 1'b0;
            e_ovr      = 1'b0;
            e_isi      = 0;
            e_iv       = 1'b0;
            m_prev     = 1'b0;
        end else begin
            edge_s    = bus.spike_in && !m_prev;
            rv_before = e_rv;
            e_iv      = 1'b0;
            if (e_rv && bus.rate_ready) e_rv = 1'b0;
            if (!m_counting) begin
                if (bus.enable) begin
                    m_counting  = 1'b1;
                    m_win_start = m_cyc + 1;
                    m_spikes    = 0;
                    m_last      = -1;
                end
            end else if (!bus.enable) begin
                m_counting = 1'b0;
            end else begin
                if (edge_s) begin
                    if (m_spikes < 255) m_spikes++;
                    if (m_last >= 0) begin
                        e_isi = ((m_cyc - m_last) > 255) ? 255 : (m_cyc - m_last);
                        e_iv  = 1'b1;
                    end
                    m_last = m_cyc;
                end
                if (((m_cyc - m_win_start) % 256) == 255) begin
                    if (rv_before && !bus.rate_ready) e_ovr = 1'b1;
                    e_rate   = m_spikes;
                    e_rv     = 1'b1;
                    m_spikes = 0;
                end
            end
            m_prev = bus.spike_in;
        end
        m_cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        chk("rate_out",   32'(bus.rate_out),   32'(e_rate));
        chk("rate_valid", 32'(bus.rate_valid), 32'(e_rv));
        chk("overrun",    32'(bus.overrun),    32'(e_ovr));
        chk("isi_out",    32'(bus.isi_out),    32'(e_isi));
        chk("isi_valid",  32'(bus.isi_valid),  32'(e_iv));
    end

    task automatic cyc1(input bit s);
        bus.spike_in = s;
        @(negedge clk);
    endtask

    task automatic align();
        int n = 0;
        while ((((m_cyc - m_win_start) % 256) != 0) && (n < 600)) begin
            cyc1(1'b0);
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("FAIL align: window start not reached within %0d cycles", n);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.spike_in   = 1'b1;
        bus.rate_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lit_reset_rate",  32'(bus.rate_out),   32'd0);
        chk("lit_reset_rv",    32'(bus.rate_valid), 32'd0);
        chk("lit_reset_ovr",   32'(bus.overrun),    32'd0);
        chk("lit_reset_isi",   32'(bus.isi_out),    32'd0);
        chk("lit_reset_iv",    32'(bus.isi_valid),  32'd0);
        reset = 1'b0;

        // Edge seen on the IDLE->COUNT cycle is dropped.
        repeat (3) cyc1(1'b1);
        chk("lit_start_rv", 32'(bus.rate_valid), 32'd0);

        for (int i = 0; i < 768; i++) cyc1((i % 16) == 0);
        chk("lit_periodic_rate", 32'(bus.rate_out), 32'd16);
        chk("lit_periodic_isi",  32'(bus.isi_out),  32'd16);
        chk("lit_periodic_ovr",  32'(bus.overrun),  32'd0);

        align();
        for (int i = 0; i < 256; i++) cyc1(1'b1);
        chk("lit_held_rate", 32'(bus.rate_out), 32'd1);
        for (int i = 0; i < 256; i++) cyc1((i % 2) == 1);
        chk("lit_toggle_rate", 32'(bus.rate_out), 32'd128);

        bus.rate_ready = 1'b0;
        for (int i = 0; i < 256; i++) cyc1(((i % 16) == 8) && (i < 80));
        chk("lit_stall_a_rate", 32'(bus.rate_out), 32'd5);
        for (int i = 0; i < 256; i++) cyc1(((i % 16) == 8) && (i < 144));
        chk("lit_stall_b_rate", 32'(bus.rate_out),   32'd9);
        chk("lit_stall_b_rv",   32'(bus.rate_valid), 32'd1);
        chk("lit_stall_b_ovr",  32'(bus.overrun),    32'd1);
        bus.rate_ready = 1'b1;
        cyc1(1'b0);
        chk("lit_accept_rv",  32'(bus.rate_valid), 32'd0);
        chk("lit_accept_ovr", 32'(bus.overrun),    32'd1);

        align();
        for (int i = 0; i < 256; i++) cyc1(i == 255);
        chk("lit_lastcycle_rate", 32'(bus.rate_out), 32'd1);
        for (int j = 1; j <= 305; j++) cyc1(j == 300);
        chk("lit_isi_sat", 32'(bus.isi_out), 32'd255);

        align();
        for (int i = 0; i < 100; i++) cyc1((i % 16) == 0);
        bus.enable = 1'b0;
        cyc1(1'b0);
        repeat (4) cyc1(1'b0);
        chk("lit_abort_rate", 32'(bus.rate_out),   32'd1);
        chk("lit_abort_rv",   32'(bus.rate_valid), 32'd0);
        chk("lit_abort_ovr",  32'(bus.overrun),    32'd1);
        chk("lit_abort_isi",  32'(bus.isi_out),    32'd16);

        bus.enable = 1'b1;
        for (int i = 0; i < 50; i++) cyc1((i % 16) == 0);
        reset = 1'b1;
        cyc1(1'b0);
        chk("lit_midreset_rate", 32'(bus.rate_out),   32'd0);
        chk("lit_midreset_rv",   32'(bus.rate_valid), 32'd0);
        chk("lit_midreset_ovr",  32'(bus.overrun),    32'd0);
        chk("lit_midreset_isi",  32'(bus.isi_out),    32'd0);
        reset = 1'b0;
        cyc1(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
